// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding and width helpers.
package systolic_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Index width that never collapses to zero bits (N=1 still needs a 1-bit index).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width: N*(2^DW-1)^2 always fits in 2*DW + clog2(N) bits.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n);
        return 2 * dw + idx_w(n);
    endfunction

    // Low bit of a lane inside a flat lane vector.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew.sv
// Triangular skew delay: lane i is delayed i cycles, lane 0 is a straight wire.
module skew_delay
    import systolic_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N*DW-1:0] data_o
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_wire
            assign data_o[DW-1:0] = data_i[DW-1:0];
        end else begin : g_dly
            logic [DW-1:0] stage_q [i];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) stage_q[s] <= '0;
                end else if (flush_i) begin
                    for (int s = 0; s < i; s++) stage_q[s] <= '0;
                end else begin
                    stage_q[0] <= data_i[lane_lo(i, DW) +: DW];
                    for (int s = 1; s < i; s++) stage_q[s] <= stage_q[s-1];
                end
            end

            assign data_o[lane_lo(i, DW) +: DW] = stage_q[i-1];
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: operand feed with skew,
// accumulate/drain timing and row-by-row result streaming under valid/ready.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = idx_w(N),
    parameter int unsigned CW = 2 * DW + AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [AW-1:0]     rd_addr_o,
    input  logic [N*DW-1:0]   a_col_i,
    input  logic [N*DW-1:0]   b_row_i,
    output logic [N*DW-1:0]   a_edge_o,
    output logic [N*DW-1:0]   b_edge_o,
    output logic              acc_clr_o,
    input  logic [N*N*CW-1:0] acc_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [AW-1:0]     res_row_o,
    output logic [N*CW-1:0]   res_data_o
);

    localparam int unsigned PW         = idx_w(2 * N);
    localparam int unsigned FEED_LAST  = N - 1;
    localparam int unsigned DRAIN_LAST = 2 * N - 2;
    localparam int unsigned ROW_LAST   = N - 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            live_q;
    logic [N*DW-1:0] a_live, b_live;

    // State register, phase counter, and buffer-latency tracker for live lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            live_q  <= (state_q == ST_FEED);
        end
    end

    // Next state; the phase counter reloads to zero on every state entry.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                    phase_d = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                phase_d = '0;
            end
            ST_FEED: begin
                if (phase_q == PW'(FEED_LAST)) begin
                    state_d = ST_DRAIN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_DRAIN: begin
                if (phase_q == PW'(DRAIN_LAST)) begin
                    state_d = ST_OUT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_OUT: begin
                if (res_ready_i) begin
                    if (phase_q == PW'(ROW_LAST)) begin
                        state_d = ST_DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        rd_en_o     = 1'b0;
        rd_addr_o   = '0;
        acc_clr_o   = 1'b0;
        res_valid_o = 1'b0;
        res_row_o   = '0;
        case (state_q)
            ST_IDLE: begin
                acc_clr_o = 1'b1;
            end
            ST_CLEAR: begin
                busy_o    = 1'b1;
                acc_clr_o = 1'b1;
            end
            ST_FEED: begin
                busy_o    = 1'b1;
                rd_en_o   = 1'b1;
                rd_addr_o = AW'(phase_q);
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
            end
            ST_OUT: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                res_row_o   = AW'(phase_q);
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                acc_clr_o = 1'b1;
            end
        endcase
    end

    // Result row mux; zero outside the output window.
    always_comb begin
        res_data_o = '0;
        if (res_valid_o) begin
            for (int unsigned j = 0; j < N; j++) begin
                res_data_o[lane_lo(j, CW) +: CW] =
                    acc_i[lane_lo(32'(res_row_o) * N + j, CW) +: CW];
            end
        end
    end

    // Only the cycle after a read carries buffer data; everything else injects zero bubbles.
    assign a_live = live_q ? a_col_i : '0;
    assign b_live = live_q ? b_row_i : '0;

    skew_delay #(.N(N), .DW(DW)) u_skew_a (
        .clk     (clk),
        .rst     (rst),
        .flush_i (acc_clr_o),
        .data_i  (a_live),
        .data_o  (a_edge_o)
    );

    skew_delay #(.N(N), .DW(DW)) u_skew_b (
        .clk     (clk),
        .rst     (rst),
        .flush_i (acc_clr_o),
        .data_i  (b_live),
        .data_o  (b_edge_o)
    );

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench: sequencer + behavioural PE grid and operand buffers, checked against C = A*B.
module tb_systolic_seq_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned CW = 18;

    typedef logic [N*CW-1:0] word_t;
    typedef struct {
        logic [AW-1:0] row;
        word_t         data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              busy_o, done_o, rd_en_o, acc_clr_o, res_valid_o;
    logic              res_ready_i = 1'b1;
    logic [AW-1:0]     rd_addr_o, res_row_o;
    logic [N*DW-1:0]   a_col_i = '0, b_row_i = '0, a_edge_o, b_edge_o;
    logic [N*N*CW-1:0] acc_i;
    word_t             res_data_o;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int beats_cnt = 0;
    int ready_mode = 0;
    int rph = 0;

    logic [DW-1:0] amat [N][N];
    logic [DW-1:0] bmat [N][N];
    beat_t         exp_q [$];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(N), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .a_col_i     (a_col_i),
        .b_row_i     (b_row_i),
        .a_edge_o    (a_edge_o),
        .b_edge_o    (b_edge_o),
        .acc_clr_o   (acc_clr_o),
        .acc_i       (acc_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_row_o   (res_row_o),
        .res_data_o  (res_data_o)
    );

    // Sync-read operand buffers; junk data when not read so unmasked bubbles would show.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en_o) begin
                a_col_i[i*DW +: DW] <= amat[i][rd_addr_o];
                b_row_i[i*DW +: DW] <= bmat[rd_addr_o][i];
            end else begin
                a_col_i[i*DW +: DW] <= DW'($urandom);
                b_row_i[i*DW +: DW] <= DW'($urandom);
            end
        end
    end

    // Behavioural output-stationary PE grid.
    logic [DW-1:0] pa_q [N][N];
    logic [DW-1:0] pb_q [N][N];
    logic [DW-1:0] ain  [N][N];
    logic [DW-1:0] bin  [N][N];
    logic [CW-1:0] pacc_q [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ain[i][j] = (j == 0) ? a_edge_o[i*DW +: DW] : pa_q[i][(j > 0) ? j-1 : 0];
                bin[i][j] = (i == 0) ? b_edge_o[j*DW +: DW] : pb_q[(i > 0) ? i-1 : 0][j];
                acc_i[(i*N+j)*CW +: CW] = pacc_q[i][j];
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!rst) begin
                    pa_q[i][j]   <= '0;
                    pb_q[i][j]   <= '0;
                    pacc_q[i][j] <= '0;
                end else begin
                    pa_q[i][j]   <= ain[i][j];
                    pb_q[i][j]   <= bin[i][j];
                    pacc_q[i][j] <= acc_clr_o ? '0 :
                                    pacc_q[i][j] + CW'(ain[i][j]) * CW'(bin[i][j]);
                end
            end
        end
    end

    task automatic check(input string name, input word_t act, input word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain matrix product, one expected beat per row.
    task automatic push_expected();
        beat_t b;
        int    c;
        for (int i = 0; i < N; i++) begin
            b.row  = AW'(i);
            b.data = '0;
            for (int j = 0; j < N; j++) begin
                c = 0;
                for (int k = 0; k < N; k++) c += int'(amat[i][k]) * int'(bmat[k][j]);
                b.data[j*CW +: CW] = CW'(c);
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (mode)
                    0: begin
                        amat[i][j] = (i == j) ? DW'(1) : DW'(0);
                        bmat[i][j] = DW'(4 * i + j);
                    end
                    1: begin amat[i][j] = DW'(255); bmat[i][j] = DW'(255); end
                    2: begin amat[i][j] = DW'(1);   bmat[i][j] = DW'(1);   end
                    default: begin
                        amat[i][j] = DW'($urandom_range(0, 255));
                        bmat[i][j] = DW'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    // Result-ready driver: always, 1-0-0 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: res_ready_i = 1'b1;
            1: begin res_ready_i = (rph % 3 == 0); rph++; end
            default: res_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst && done_o) done_cnt++;
    end

    // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
    logic          held_v = 1'b0;
    word_t         held_data;
    logic [AW-1:0] held_row;
    beat_t         got;

    always @(negedge clk) begin
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", word_t'(res_valid_o), word_t'(1));
                check("hold_row", word_t'(res_row_o), word_t'(held_row));
                check("hold_data", res_data_o, held_data);
            end
            if (res_valid_o && res_ready_i) begin
                beats_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_unexpected: row %0d data 0x%0h with empty scoreboard", res_row_o, res_data_o);
                end else begin
                    got = exp_q.pop_front();
                    check("beat_row", word_t'(res_row_o), word_t'(got.row));
                    check("beat_data", res_data_o, got.data);
                end
            end
            held_v    = res_valid_o && !res_ready_i;
            held_data = res_data_o;
            held_row  = res_row_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start();
        push_expected();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_jobs(input int target, input string name);
        for (int n = 0; n < 400 && done_cnt < target; n++) @(negedge clk);
        check({name, "_done_count"}, word_t'(done_cnt), word_t'(target));
        tick();
        tick();
        check({name, "_sb_empty"}, word_t'(exp_q.size()), word_t'(0));
        check({name, "_idle"}, word_t'(busy_o), word_t'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, word_t'(busy_o), word_t'(0));
        check({name, "_done"}, word_t'(done_o), word_t'(0));
        check({name, "_rd_en"}, word_t'(rd_en_o), word_t'(0));
        check({name, "_acc_clr"}, word_t'(acc_clr_o), word_t'(1));
        check({name, "_valid"}, word_t'(res_valid_o), word_t'(0));
        check({name, "_a_edge"}, word_t'(a_edge_o), word_t'(0));
        check({name, "_b_edge"}, word_t'(b_edge_o), word_t'(0));
    endtask

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Job 1: identity A, cycle-exact timeline with ready held high.
        push_expected();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", n), word_t'(busy_o), word_t'(n <= 17));
            check($sformatf("t1_done_c%0d", n), word_t'(done_o), word_t'(n == 17));
            check($sformatf("t1_clr_c%0d", n), word_t'(acc_clr_o), word_t'(n == 1 || n == 18));
            check($sformatf("t1_rd_en_c%0d", n), word_t'(rd_en_o), word_t'(n >= 2 && n <= 5));
            check($sformatf("t1_valid_c%0d", n), word_t'(res_valid_o), word_t'(n >= 13 && n <= 16));
            if (n >= 2 && n <= 5)
                check($sformatf("t1_rd_addr_c%0d", n), word_t'(rd_addr_o), word_t'(n - 2));
        end
        wait_jobs(1, "t1");

        // Job 2: saturated operands.
        fill(1);
        issue_start();
        wait_jobs(2, "t2");

        // Job 3: all ones with a 1,0,0 ready pattern.
        fill(2);
        rph = 0;
        ready_mode = 1;
        begin
            int b0;
            b0 = beats_cnt;
            issue_start();
            wait_jobs(3, "t3");
            check("t3_handshakes", word_t'(beats_cnt - b0), word_t'(N));
        end
        ready_mode = 0;

        // Job 4: stray starts during FEED and OUT are ignored.
        fill(3);
        ready_mode = 2;
        issue_start();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int n = 0; n < 100 && !res_valid_o; n++) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_jobs(4, "t4");
        repeat (30) tick();
        check("t4_single_done", word_t'(done_cnt), word_t'(4));
        check("t4_still_idle", word_t'(busy_o), word_t'(0));
        ready_mode = 0;

        // Job 5: reset pulse in the middle of FEED, then a fresh job.
        fill(3);
        push_expected();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("t5_pre_rst_rd_en", word_t'(rd_en_o), word_t'(1));
        rst = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        exp_q.delete();
        tick();
        rst = 1'b1;
        check_reset_outputs("t5_post_rst");
        fill(3);
        issue_start();
        wait_jobs(5, "t5");

        // Jobs 6/7: start held across DONE into the first IDLE cycle gives one new job.
        fill(3);
        issue_start();
        for (int n = 0; n < 100 && !done_o; n++) @(negedge clk);
        check("t6_done_seen", word_t'(done_o), word_t'(1));
        fill(3);
        push_expected();
        start_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("t6_restarted", word_t'(busy_o), word_t'(1));
        wait_jobs(7, "t6");
        repeat (30) tick();
        check("t6_single_restart", word_t'(done_cnt), word_t'(7));

        // Random jobs with random backpressure.
        ready_mode = 2;
        for (int j = 0; j < 5; j++) begin
            fill(3);
            issue_start();
            wait_jobs(8 + j, "rand");
        end
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
